// File: rtl/layer2_pkg.sv
// layer2_pkg: shared configuration for the conv layer-2 window generator.
//   DATA_W/MAP_W/MAP_H/K/FRAME_BEATS : base geometry of the pooled layer-1 map
//   PIX_PER_FRAME/OUT_DIM/WIN_PER_FRAME : derived frame and output sizes
//   IDX_W   : width of the window index (oy*OUT_DIM+ox)
//   pixel_t : signed pixel type
package layer2_pkg;

    localparam int DATA_W        = 16;
    localparam int MAP_W         = 12;
    localparam int MAP_H         = 12;
    localparam int K             = 5;
    localparam int FRAME_BEATS   = 160;

    localparam int PIX_PER_FRAME = MAP_W * MAP_H;
    localparam int OUT_DIM       = MAP_W - K + 1;
    localparam int WIN_PER_FRAME = OUT_DIM * OUT_DIM;
    localparam int IDX_W         = $clog2(WIN_PER_FRAME);

    typedef logic signed [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/layer2_window_gen_if.sv
// layer2_window_gen_if: pixel stream in / window stream out of the layer-2
// window generator.
//   datain, layer2_en               : pixel beat from the layer-1 ping-pong buffer
//   window, win_valid, win_idx      : 5x5 window to the layer-2 MAC array
//   frame_done                      : end-of-frame pulse
// Modports: master = upstream/downstream environment, slave = the generator.
interface layer2_window_gen_if;
    import layer2_pkg::*;

    pixel_t                   datain;
    logic                     layer2_en;
    logic [K*K*DATA_W-1:0]    window;
    logic                     win_valid;
    logic [IDX_W-1:0]         win_idx;
    logic                     frame_done;

    modport master (
        output datain, layer2_en,
        input  window, win_valid, win_idx, frame_done
    );

    modport slave (
        input  datain, layer2_en,
        output window, win_valid, win_idx, frame_done
    );

endinterface

// File: rtl/layer2_line_buf.sv
// layer2_line_buf: DEPTH-deep shift-register delay line with enable.
//   clk  : clock
//   en   : advance the line by one entry
//   din  : entry written at the head
//   dout : entry written DEPTH enabled cycles ago
// Contents are intentionally not reset.
module layer2_line_buf #(
    parameter int DEPTH = 12,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            sr[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/layer2_window_gen.sv
// layer2_window_gen: streaming KxK window generator for conv layer 2.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport of layer2_window_gen_if
//              (datain/layer2_en in; window/win_valid/win_idx/frame_done out)
// Optional feature macro: LAYER2_WIN_RELU_EN clamps negative pixels to 0
// before they enter the line buffers and window.
module layer2_window_gen
    import layer2_pkg::*;
#(
    parameter int DATA_W      = layer2_pkg::DATA_W,
    parameter int MAP_W       = layer2_pkg::MAP_W,
    parameter int MAP_H       = layer2_pkg::MAP_H,
    parameter int K           = layer2_pkg::K,
    parameter int FRAME_BEATS = layer2_pkg::FRAME_BEATS
) (
    input  logic               clk,
    input  logic               rst,
    layer2_window_gen_if.slave bus
);

    localparam int BEAT_W = $clog2(FRAME_BEATS);
    localparam int COL_W  = $clog2(MAP_W);
    localparam int ROW_W  = $clog2(MAP_H);
    localparam int OUT_D  = MAP_W - K + 1;
    localparam int IW     = $clog2(OUT_D * OUT_D);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);
    localparam logic [BEAT_W-1:0] PIX_LIM   = BEAT_W'(MAP_W * MAP_H);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(MAP_W - 1);
    localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(K - 1);
    localparam logic [ROW_W-1:0]  ROW_FIRST = ROW_W'(K - 1);

    logic [BEAT_W-1:0]        beat_cnt;
    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic                     is_pix;
    logic                     pix_ok;
    logic signed [DATA_W-1:0] pix_in;
    logic [DATA_W-1:0]        lb_in  [K-1];
    logic [DATA_W-1:0]        lb_out [K-1];
    logic signed [DATA_W-1:0] tap    [K];
    logic signed [DATA_W-1:0] win_q  [K][K];
    logic [K*K*DATA_W-1:0]    win_flat;
    logic                     valid_q;
    logic [IW-1:0]            idx_q;
    logic                     done_q;
    logic [IW-1:0]            oy;
    logic [IW-1:0]            ox;

`ifdef LAYER2_WIN_RELU_EN
    assign pix_in = bus.datain[DATA_W-1] ? '0 : bus.datain;
`else
    assign pix_in = bus.datain;
`endif

    assign is_pix = (beat_cnt < PIX_LIM);
    // Reset wins over a concurrent beat, so the line buffers must not advance.
    assign pix_ok = bus.layer2_en && !rst && is_pix;

    // Line buffers chained: buffer i delays by i+1 rows; tap[0] is the oldest row.
    always_comb begin
        for (int unsigned i = 0; i < K - 1; i++) begin
            lb_in[i] = (i == 0) ? pix_in : lb_out[i-1];
        end
        for (int unsigned i = 0; i < K - 1; i++) begin
            tap[K-2-i] = lb_out[i];
        end
        tap[K-1] = pix_in;
    end

    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        layer2_line_buf #(.DEPTH(MAP_W), .W(DATA_W)) u_lb (
            .clk  (clk),
            .en   (pix_ok),
            .din  (lb_in[g]),
            .dout (lb_out[g])
        );
    end

    assign oy = IW'(row - ROW_FIRST);
    assign ox = IW'(col - COL_FIRST);

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            row      <= '0;
            col      <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            valid_q <= 1'b0;
            done_q  <= bus.layer2_en && (beat_cnt == LAST_BEAT);
            if (bus.layer2_en) begin
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt <= '0;
                    row      <= '0;
                    col      <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (is_pix) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                if (is_pix) begin
                    for (int unsigned r = 0; r < K; r++) begin
                        for (int unsigned c = 0; c < K - 1; c++) begin
                            win_q[r][c] <= win_q[r][c+1];
                        end
                        win_q[r][K-1] <= tap[r];
                    end
                    // Columns left over from the previous row occupy the window
                    // while col < K-1; masking them here hides them.
                    if (row >= ROW_FIRST && col >= COL_FIRST) begin
                        valid_q <= 1'b1;
                        idx_q   <= IW'(oy * IW'(OUT_D) + ox);
                    end
                end
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                win_flat[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
            end
        end
    end

    assign bus.window     = win_flat;
    assign bus.win_valid  = valid_q;
    assign bus.win_idx    = idx_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_layer2_window_gen.sv
module tb_layer2_window_gen;
    import layer2_pkg::*;

    typedef struct {
        logic [IDX_W-1:0]      idx;
        logic [K*K*DATA_W-1:0] win;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    layer2_window_gen_if bus ();

    layer2_window_gen #(
        .DATA_W      (DATA_W),
        .MAP_W       (MAP_W),
        .MAP_H       (MAP_H),
        .K           (K),
        .FRAME_BEATS (FRAME_BEATS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t   sb [$];
    pixel_t img [PIX_PER_FRAME];
    int     checks = 0;
    int     errors = 0;
    int     tb_beat = 0;
    logic   pend_valid = 1'b0;
    logic   pend_fd = 1'b0;
    logic   pend_rst = 1'b1;
    int     win_seen = 0;
    int     fd_seen = 0;
    int     fd_cyc [$];
    logic   got_first = 1'b0;
    logic [K*K*DATA_W-1:0] first_win;
    logic [K*K*DATA_W-1:0] last_win;

    function automatic pixel_t relu(input pixel_t p);
`ifdef LAYER2_WIN_RELU_EN
        return (p < 0) ? pixel_t'(0) : p;
`else
        return p;
`endif
    endfunction

    task automatic check_outputs();
        exp_t e;
        checks++;
        assert (bus.win_valid === pend_valid) else begin
            errors++;
            $error("FAIL win_valid: observed %b expected %b (cycle %0d)", bus.win_valid, pend_valid, cyc);
        end
        checks++;
        assert (bus.frame_done === pend_fd) else begin
            errors++;
            $error("FAIL frame_done: observed %b expected %b (cycle %0d)", bus.frame_done, pend_fd, cyc);
        end
        if (pend_rst) begin
            checks++;
            assert (bus.window === '0) else begin
                errors++;
                $error("FAIL reset_window: observed %h expected 0", bus.window);
            end
            checks++;
            assert (bus.win_idx === '0) else begin
                errors++;
                $error("FAIL reset_idx: observed %0d expected 0", bus.win_idx);
            end
        end
        if (pend_valid) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL scoreboard: observed empty queue expected an entry (cycle %0d)", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert (bus.win_idx === e.idx) else begin
                    errors++;
                    $error("FAIL win_idx: observed %0d expected %0d", bus.win_idx, e.idx);
                end
                checks++;
                assert (bus.window === e.win) else begin
                    errors++;
                    $error("FAIL window idx %0d: observed %h expected %h", e.idx, bus.window, e.win);
                end
            end
        end
        if (bus.win_valid === 1'b1) begin
            win_seen++;
            if (!got_first) first_win = bus.window;
            got_first = 1'b1;
            last_win  = bus.window;
        end
        if (bus.frame_done === 1'b1) begin
            fd_seen++;
            fd_cyc.push_back(cyc);
        end
    endtask

    task automatic model(input pixel_t d, input logic en, input logic r);
        exp_t e;
        int   row;
        int   col;
        pend_valid = 1'b0;
        pend_fd    = 1'b0;
        if (r) begin
            pend_rst = 1'b1;
            tb_beat  = 0;
            sb.delete();
        end else begin
            pend_rst = 1'b0;
            if (en) begin
                if (tb_beat < PIX_PER_FRAME) begin
                    img[tb_beat] = relu(d);
                    row = tb_beat / MAP_W;
                    col = tb_beat % MAP_W;
                    if (row >= K - 1 && col >= K - 1) begin
                        e.idx = IDX_W'((row - (K - 1)) * OUT_DIM + (col - (K - 1)));
                        e.win = '0;
                        for (int wr = 0; wr < K; wr++) begin
                            for (int wc = 0; wc < K; wc++) begin
                                e.win[(wr*K+wc)*DATA_W +: DATA_W] =
                                    img[(row - (K - 1) + wr) * MAP_W + (col - (K - 1) + wc)];
                            end
                        end
                        sb.push_back(e);
                        pend_valid = 1'b1;
                    end
                end
                pend_fd = (tb_beat == FRAME_BEATS - 1);
                tb_beat = (tb_beat + 1) % FRAME_BEATS;
            end
        end
    endtask

    task automatic step(input pixel_t d, input logic en, input logic r);
        @(negedge clk);
        check_outputs();
        bus.datain    = d;
        bus.layer2_en = en;
        rst           = r;
        model(d, en, r);
        @(posedge clk);
    endtask

    task automatic begin_test();
        win_seen  = 0;
        fd_seen   = 0;
        got_first = 1'b0;
        fd_cyc.delete();
    endtask

    task automatic check_count(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic pixel_t ramp(input int n, input int base);
        return (n < PIX_PER_FRAME) ? pixel_t'(n + base) : pixel_t'(16'h7FFF);
    endfunction

    initial begin
        bus.datain    = '0;
        bus.layer2_en = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);

        // Ramp frame, continuous
        begin_test();
        for (int n = 0; n < FRAME_BEATS; n++) step(ramp(n, 0), 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        check_count("ramp_windows", win_seen, WIN_PER_FRAME);
        check_count("ramp_frame_done", fd_seen, 1);
        check_count("ramp_first_00", int'(pixel_t'(first_win[0 +: DATA_W])), 0);
        check_count("ramp_first_44", int'(pixel_t'(first_win[(K*K-1)*DATA_W +: DATA_W])), 52);
        check_count("ramp_last_00", int'(pixel_t'(last_win[0 +: DATA_W])), 91);

        // Gapped input
        begin_test();
        for (int n = 0; n < FRAME_BEATS; n++) begin
            step(ramp(n, 0), 1'b1, 1'b0);
            step(pixel_t'(16'h5A5A), 1'b0, 1'b0);
        end
        step('0, 1'b0, 1'b0);
        check_count("gap_windows", win_seen, WIN_PER_FRAME);
        check_count("gap_frame_done", fd_seen, 1);

        // Back-to-back frames
        begin_test();
        for (int n = 0; n < FRAME_BEATS; n++) step(ramp(n, 0), 1'b1, 1'b0);
        for (int n = 0; n < FRAME_BEATS; n++) step(ramp(n, 1000), 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        check_count("b2b_windows", win_seen, 2 * WIN_PER_FRAME);
        check_count("b2b_frame_done", fd_seen, 2);
        if (fd_cyc.size() == 2) check_count("b2b_fd_spacing", fd_cyc[1] - fd_cyc[0], FRAME_BEATS);
        check_count("b2b_last_00", int'(pixel_t'(last_win[0 +: DATA_W])), 1091);

        // Mid-frame reset at beat 70
        for (int n = 0; n < 70; n++) step(ramp(n, 0), 1'b1, 1'b0);
        step(ramp(70, 0), 1'b1, 1'b1);
        begin_test();
        for (int n = 0; n < FRAME_BEATS; n++) step(ramp(n, 0), 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        check_count("rst_windows", win_seen, WIN_PER_FRAME);
        check_count("rst_frame_done", fd_seen, 1);
        check_count("rst_first_00", int'(pixel_t'(first_win[0 +: DATA_W])), 0);

        // Signed ramp: pixel n = n-72
        begin_test();
        for (int n = 0; n < FRAME_BEATS; n++) step(ramp(n, -72), 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        check_count("signed_windows", win_seen, WIN_PER_FRAME);
        check_count("signed_first_00", int'(pixel_t'(first_win[0 +: DATA_W])), int'(relu(pixel_t'(-72))));
        check_count("signed_last_44", int'(pixel_t'(last_win[(K*K-1)*DATA_W +: DATA_W])), 71);

        check_count("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer2_window_gen.md
# layer2_window_gen

Streaming 5x5 window generator for conv layer 2. It consumes the pooled layer-1 feature map from the layer-1 ping-pong buffer's read port: 16-bit signed pixels, one per cycle, qualified by `layer2_en`, 160 beats per frame, of which the first 144 are a 12x12 map in raster order and the last 16 are padding. It presents every valid 5x5 neighbourhood (8x8 = 64 windows per frame) to the layer-2 MAC array, one window per cycle.

## Interface
Parameters:
- `DATA_W`, 16, pixel width (signed)
- `MAP_W`, 12, map width in pixels
- `MAP_H`, 12, map height in pixels
- `K`, 5, kernel size
- `FRAME_BEATS`, 160, beats per frame, including padding

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `datain` in DATA_W: signed pixel
- `layer2_en` in 1: beat valid; `datain` is sampled on each `clk` edge where `layer2_en`=1
- `window` out K*K*DATA_W: element (r,c) at bits `[(r*K+c)*DATA_W +: DATA_W]`; r=0 is the top row, c=0 the leftmost column
- `win_valid` out 1: `window` and `win_idx` are valid this cycle
- `win_idx` out 6: output position, oy*8+ox, 0..63
- `frame_done` out 1: one-cycle pulse after the last beat of a frame

## Operation
- `beat_cnt` counts 0..FRAME_BEATS-1 on accepted beats; it wraps to 0 after FRAME_BEATS-1.
- Beats with `beat_cnt` < MAP_W*MAP_H are pixels. `col` and `row` track the pixel position in raster order.
- Beats with `beat_cnt` >= 144 are padding. They are discarded: no line-buffer write, no window shift, no `win_valid`.
- Line buffers: K-1 = 4 row delay lines, each MAP_W deep.
- On each pixel, the 5x5 register window shifts left by one column. The new right column is built from the four line-buffer taps (oldest on top) with `datain` at the bottom. The line buffers then advance.
- A window is valid when `row` >= K-1 and `col` >= K-1. In that case `oy` = row-4, `ox` = col-4.
- Columns from the previous row's tail sit in the window at `col` < 4. They are never emitted because of the masking rule above.
- When `layer2_en`=0, all state holds.
- Pixel arithmetic: none, pass-through, except the optional ReLU (see Configuration).

## Timing
- Reset values: `window`=0, `win_valid`=0, `win_idx`=0, `frame_done`=0. `beat_cnt`, `row` and `col` are also 0.
- Line-buffer contents are not cleared on reset. The row masking makes stale data unobservable.
- Latency: `win_valid` rises on the edge after the completing pixel is sampled (1 cycle). Outputs are registered.
- `win_valid` is a pulse per accepted completing pixel. Back-to-back pixels give consecutive valid cycles. Gaps in `layer2_en` give gaps in `win_valid`.
- `frame_done` is asserted for exactly one cycle, on the cycle after beat FRAME_BEATS-1 is sampled.
- Back-to-back frames: beat 0 of the next frame may arrive on the cycle directly after beat 159. It is treated as pixel (0,0) with no bubble, and `frame_done` coincides with its acceptance.
- Reset mid-frame (`rst`=1 with `layer2_en`=1): reset wins. The beat is dropped, and the next accepted beat is beat 0.
- No backpressure: the downstream block must accept one window per cycle.

## Configuration
- `LAYER2_WIN_RELU_EN` defined: a negative `datain` is replaced by 0 before entering the line buffers and window.
- `LAYER2_WIN_RELU_EN` undefined: pixels pass unmodified.
- Neither setting changes ports or timing.

## Structure
- Package `layer2_pkg`:
  - `DATA_W`, `MAP_W`, `MAP_H`, `K`, `FRAME_BEATS`
  - derived `PIX_PER_FRAME`=144, `OUT_DIM`=8, `WIN_PER_FRAME`=64
  - `pixel_t` (signed DATA_W)
- Sub-module `layer2_line_buf`: one MAP_W-deep shift-register delay line with an enable. It is instantiated K-1 times.

## Test plan
- **Ramp frame:** drive pixel n = n for n = 0..143, then 16 padding beats of 16'h7FFF, continuous `layer2_en`.
  - First `win_valid` occurs 1 cycle after beat 52 with `win_idx`=0 and element (r,c) = r*12+c.
  - There are 64 valid cycles; the last is at `win_idx`=63 with element (0,0)=91.
  - `frame_done` fires 1 cycle after beat 159.
  - No window contains 7FFF.
- **Gapped input:** same ramp with `layer2_en` toggling 1/0 every cycle. The windows are identical and in the same order, with `win_valid` spaced by the gaps.
- **Back-to-back frames:** two ramp frames with no gap; the second frame uses pixel = n+1000.
  - Second frame's first window has (0,0)=1000; no window mixes values from both frames.
  - Exactly 128 windows in total; two `frame_done` pulses, 160 cycles apart.
- **Mid-frame reset:** assert `rst` for 1 cycle at beat 70, then send a full ramp frame.
  - All outputs are 0 during reset.
  - Next window has `win_idx`=0 with (0,0)=0; 64 windows follow, then `frame_done`.
- **ReLU enabled** (`LAYER2_WIN_RELU_EN`): pixel n = n-72.
  - Window 0 shows 0 for every negative source pixel.
  - Window 63 has (4,4)=71.
  - Without the macro, window 0 has (0,0)=-72.
